// File: rtl/sha1_pkg.sv
// Shared types, constants and round helper functions for the streaming SHA-1 engine.
package sha1_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned DIGEST_W    = 160;
    localparam int unsigned WIN_DEPTH   = 16;
    localparam int unsigned SHA1_ROUNDS = 80;

    // Five-word working/chaining state; a (H0) sits in the most significant word.
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] c;
        logic [WORD_W-1:0] d;
        logic [WORD_W-1:0] e;
    } sha1_state_t;

    // Rolling message window; element 0 is the MSB word so a block loads directly.
    typedef logic [0:WIN_DEPTH-1][WORD_W-1:0] sha1_win_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_OUT    = 2'd3
    } sha1_fsm_t;

    localparam sha1_state_t SHA1_IV = '{
        a: 32'h67452301,
        b: 32'hEFCDAB89,
        c: 32'h98BADCFE,
        d: 32'h10325476,
        e: 32'hC3D2E1F0
    };

    localparam logic [WORD_W-1:0] K_00_19 = 32'h5A827999;
    localparam logic [WORD_W-1:0] K_20_39 = 32'h6ED9EBA1;
    localparam logic [WORD_W-1:0] K_40_59 = 32'h8F1BBCDC;
    localparam logic [WORD_W-1:0] K_60_79 = 32'hCA62C1D6;

    // True rotate-left; n is always a constant in 1..31.
    function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] f_ch(input logic [WORD_W-1:0] b,
                                               input logic [WORD_W-1:0] c,
                                               input logic [WORD_W-1:0] d);
        return (b & c) | (~b & d);
    endfunction

    function automatic logic [WORD_W-1:0] f_par(input logic [WORD_W-1:0] b,
                                                input logic [WORD_W-1:0] c,
                                                input logic [WORD_W-1:0] d);
        return b ^ c ^ d;
    endfunction

    function automatic logic [WORD_W-1:0] f_maj(input logic [WORD_W-1:0] b,
                                                input logic [WORD_W-1:0] c,
                                                input logic [WORD_W-1:0] d);
        return (b & c) | (b & d) | (c & d);
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round; f and K are chosen from the round's own index so
// chained instances may cross a 20-round group boundary.
module sha1_round
    import sha1_pkg::*;
#(
    parameter int unsigned IDX_W = 7
) (
    input  sha1_state_t        st_i,
    input  logic [WORD_W-1:0]  w_i,
    input  logic [IDX_W-1:0]   t_i,
    output sha1_state_t        st_o
);

    logic [WORD_W-1:0] f_val;
    logic [WORD_W-1:0] k_val;

    // Select round function and constant by round group, then apply the round.
    always_comb begin : p_round
        f_val = f_par(st_i.b, st_i.c, st_i.d);
        k_val = K_60_79;
        if (t_i < IDX_W'(20)) begin
            f_val = f_ch(st_i.b, st_i.c, st_i.d);
            k_val = K_00_19;
        end else if (t_i < IDX_W'(40)) begin
            k_val = K_20_39;
        end else if (t_i < IDX_W'(60)) begin
            f_val = f_maj(st_i.b, st_i.c, st_i.d);
            k_val = K_40_59;
        end
        st_o.a = rotl32(st_i.a, 5) + f_val + st_i.e + k_val + w_i;
        st_o.b = st_i.a;
        st_o.c = rotl32(st_i.b, 30);
        st_o.d = st_i.c;
        st_o.e = st_i.d;
    end

endmodule

// File: rtl/sha1_stream_core.sv
// Multi-block SHA-1 compression engine: valid/ready block input, H chaining across
// blocks, rolling 16-word schedule and ROUNDS_PER_CYCLE rounds per clock.
module sha1_stream_core
    import sha1_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned IDX_W            = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                block_valid,
    output logic                block_ready,
    input  logic [BLOCK_W-1:0]  block_data,
    input  logic                block_first,
    input  logic                block_last,
    input  logic                abort,
    output logic                digest_valid,
    input  logic                digest_ready,
    output logic [DIGEST_W-1:0] digest_data,
    output logic                busy,
    output logic [IDX_W-1:0]    round_idx
);

    localparam int unsigned RPC      = ROUNDS_PER_CYCLE;
    localparam int unsigned LAST_IDX = SHA1_ROUNDS - RPC;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5)) begin : g_bad_rpc
        $fatal(1, "sha1_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
    end
    if (IDX_W < 7) begin : g_bad_idx_w
        $fatal(1, "sha1_stream_core: IDX_W must hold 0..80");
    end

    sha1_fsm_t             state_q, state_d;
    sha1_win_t             win_q, win_d, win_adv;
    sha1_state_t           h_q, h_d, h_sum;
    sha1_state_t           work_q, work_d, round_out;
    logic                  last_q, last_d;
    logic [IDX_W-1:0]      ridx_q, ridx_d;
    logic [DIGEST_W-1:0]   digest_q, digest_d;
    logic                  dvalid_q, dvalid_d;
    logic                  bready_q, bready_d;
    logic                  busy_q, busy_d;

    // Round chain: instance k executes round t+k on window word k.
    for (genvar k = 0; k < RPC; k++) begin : g_rnd
        sha1_state_t st_in;
        sha1_state_t st_out;
        if (k == 0) begin : g_head
            assign st_in = work_q;
        end else begin : g_link
            assign st_in = g_rnd[k-1].st_out;
        end
        sha1_round #(.IDX_W(IDX_W)) u_round (
            .st_i (st_in),
            .w_i  (win_q[k]),
            .t_i  (ridx_q + IDX_W'(k)),
            .st_o (st_out)
        );
    end
    assign round_out = g_rnd[RPC-1].st_out;

    // Extend the window by RPC schedule words (later ones may depend on earlier new ones), then shift.
    always_comb begin : p_sched
        logic [WORD_W-1:0] ext [WIN_DEPTH+RPC];
        for (int unsigned j = 0; j < WIN_DEPTH; j++) begin
            ext[j] = win_q[j];
        end
        for (int unsigned j = 0; j < RPC; j++) begin
            ext[WIN_DEPTH+j] = rotl32(ext[13+j] ^ ext[8+j] ^ ext[2+j] ^ ext[j], 1);
        end
        for (int unsigned j = 0; j < WIN_DEPTH; j++) begin
            win_adv[j] = ext[RPC+j];
        end
    end

    // Chaining add of the finished working state into H.
    always_comb begin : p_hsum
        h_sum.a = h_q.a + work_q.a;
        h_sum.b = h_q.b + work_q.b;
        h_sum.c = h_q.c + work_q.c;
        h_sum.d = h_q.d + work_q.d;
        h_sum.e = h_q.e + work_q.e;
    end

    // Next-state and datapath update; abort overrides every transition.
    always_comb begin : p_next
        state_d  = state_q;
        win_d    = win_q;
        h_d      = h_q;
        work_d   = work_q;
        last_d   = last_q;
        ridx_d   = ridx_q;
        digest_d = digest_q;
        dvalid_d = dvalid_q;
        bready_d = bready_q;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (block_valid) begin
                    win_d   = sha1_win_t'(block_data);
                    last_d  = block_last;
                    ridx_d  = '0;
                    if (block_first) begin
                        h_d = SHA1_IV;
                    end
                    work_d  = block_first ? SHA1_IV : h_q;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                work_d = round_out;
                win_d  = win_adv;
                if (ridx_q == IDX_W'(LAST_IDX)) begin
                    ridx_d  = '0;
                    state_d = ST_UPDATE;
                end else begin
                    ridx_d = ridx_q + IDX_W'(RPC);
                end
            end
            ST_UPDATE: begin
                h_d = h_sum;
                if (last_q) begin
                    digest_d = DIGEST_W'(h_sum);
                    dvalid_d = 1'b1;
                    state_d  = ST_OUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (digest_ready) begin
                    dvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d  = ST_IDLE;
            dvalid_d = 1'b0;
            h_d      = SHA1_IV;
            ridx_d   = '0;
        end

        bready_d = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin : p_regs
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            h_q      <= SHA1_IV;
            work_q   <= '0;
            last_q   <= 1'b0;
            ridx_q   <= '0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
            bready_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            h_q      <= h_d;
            work_q   <= work_d;
            last_q   <= last_d;
            ridx_q   <= ridx_d;
            digest_q <= digest_d;
            dvalid_q <= dvalid_d;
            bready_q <= bready_d;
            busy_q   <= busy_d;
        end
    end

    assign block_ready  = bready_q;
    assign busy         = busy_q;
    assign round_idx    = ridx_q;
    assign digest_valid = dvalid_q;
    assign digest_data  = digest_q;

endmodule

// File: tb/tb_sha1_stream_core.sv
// Bench for sha1_stream_core: four instances (1,2,4,5 rounds per clock) checked
// against known digests and a plain 80-word SHA-1 reference model.
module tb_sha1_stream_core;

    localparam logic [159:0] IV_H    = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] ABC_D   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] EMPTY_D = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] TWO_D   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
    localparam logic [511:0] ABC_B   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO1_B  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO2_B  = {448'h0, 64'h1c0};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         bv [4];
    logic         bf [4];
    logic         bl [4];
    logic         ab [4];
    logic         dr [4];
    logic [511:0] bd [4];
    logic         br [4];
    logic         dv [4];
    logic         bs [4];
    logic [159:0] dd [4];
    logic [6:0]   ri [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha1_stream_core #(
            .ROUNDS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5),
            .IDX_W(7)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .block_valid  (bv[g]),
            .block_ready  (br[g]),
            .block_data   (bd[g]),
            .block_first  (bf[g]),
            .block_last   (bl[g]),
            .abort        (ab[g]),
            .digest_valid (dv[g]),
            .digest_ready (dr[g]),
            .digest_data  (dd[g]),
            .busy         (bs[g]),
            .round_idx    (ri[g])
        );
    end

    function automatic int rv(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Textbook SHA-1 compression with a fully expanded 80-word schedule.
    function automatic logic [159:0] ref_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
        a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
            tmp = rol(a, 5) + f + e + k + w[t];
            e = d; d = c; c = rol(b, 30); b = a; a = tmp;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a block at a negedge and hold it until accepted; returns at the negedge after acceptance.
    task automatic send(input int i, input logic [511:0] d, input logic f, input logic l);
        int n;
        n = 0;
        bv[i] = 1'b1; bd[i] = d; bf[i] = f; bl[i] = l;
        while (br[i] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk("send_timeout", 160'(n < 300), 160'(1));
        @(negedge clk);
        bv[i] = 1'b0;
    endtask

    // Count clock edges from acceptance until digest_valid.
    task automatic wait_dig(input int i, output int lat);
        lat = 0;
        while (dv[i] !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
        chk("digest_timeout", 160'(lat < 400), 160'(1));
    endtask

    task automatic take(input int i);
        dr[i] = 1'b1;
        @(negedge clk);
        dr[i] = 1'b0;
        chk("dv_after_take", 160'(dv[i]), 160'(0));
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (br[i] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk("idle_timeout", 160'(n < 300), 160'(1));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_dv"},   160'(dv[0]), 160'(0));
        chk({tag, "_dd"},   dd[0],       160'(0));
        chk({tag, "_br"},   160'(br[0]), 160'(1));
        chk({tag, "_busy"}, 160'(bs[0]), 160'(0));
        chk({tag, "_ridx"}, 160'(ri[0]), 160'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        logic [159:0] hm;
        logic [511:0] blk;
        int nblk;

        for (int i = 0; i < 4; i++) begin
            bv[i] = 0; bf[i] = 0; bl[i] = 0; ab[i] = 0; dr[i] = 0; bd[i] = '0;
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // "abc" single block at one round per clock, with exact latency.
        send(0, ABC_B, 1'b1, 1'b1);
        wait_dig(0, lat);
        chk("abc_latency", 160'(lat), 160'(81));
        chk("abc_digest", dd[0], ABC_D);
        take(0);

        // Empty message on every rounds-per-cycle variant.
        for (int i = 0; i < 4; i++) begin
            send(i, EMPTY_B, 1'b1, 1'b1);
            wait_dig(i, lat);
            chk("empty_latency", 160'(lat), 160'(80 / rv(i) + 1));
            chk("empty_digest", dd[i], EMPTY_D);
            take(i);
        end

        // Two-block message: no digest after the first block.
        send(0, TWO1_B, 1'b1, 1'b0);
        wait_idle(0);
        chk("two_no_mid_digest", 160'(dv[0]), 160'(0));
        send(0, TWO2_B, 1'b0, 1'b1);
        wait_dig(0, lat);
        chk("two_digest", dd[0], TWO_D);
        take(0);

        // Backpressure: digest held for 20 cycles while a waiting block is refused.
        send(0, ABC_B, 1'b1, 1'b1);
        wait_dig(0, lat);
        bv[0] = 1'b1; bd[0] = EMPTY_B; bf[0] = 1'b1; bl[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_digest_held", dd[0], ABC_D);
            chk("bp_valid_held", 160'(dv[0]), 160'(1));
            chk("bp_not_ready", 160'(br[0]), 160'(0));
        end
        dr[0] = 1'b1;
        @(negedge clk);
        dr[0] = 1'b0;
        chk("bp_released", 160'(dv[0]), 160'(0));
        chk("bp_idle_ready", 160'(br[0]), 160'(1));
        @(negedge clk);
        bv[0] = 1'b0;
        chk("bp_accept_next", 160'(bs[0]), 160'(1));
        wait_dig(0, lat);
        chk("bp_latency", 160'(lat), 160'(81));
        chk("bp_digest", dd[0], EMPTY_D);
        take(0);

        // Abort at round 40 of the second block, then a fresh "abc".
        send(0, TWO1_B, 1'b1, 1'b0);
        wait_idle(0);
        send(0, TWO2_B, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        chk("abort_at_round", 160'(ri[0]), 160'(40));
        chk("abort_busy_before", 160'(bs[0]), 160'(1));
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("abort_busy", 160'(bs[0]), 160'(0));
        chk("abort_ridx", 160'(ri[0]), 160'(0));
        chk("abort_dv", 160'(dv[0]), 160'(0));
        chk("abort_ready", 160'(br[0]), 160'(1));
        send(0, ABC_B, 1'b1, 1'b1);
        wait_dig(0, lat);
        chk("abort_abc_latency", 160'(lat), 160'(81));
        chk("abort_abc_digest", dd[0], ABC_D);
        take(0);

        // Abort while idle with an intermediate H: a non-first block then starts from IV.
        send(0, TWO1_B, 1'b1, 1'b0);
        wait_idle(0);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        send(0, ABC_B, 1'b0, 1'b1);
        wait_dig(0, lat);
        chk("idle_abort_digest", dd[0], ABC_D);
        take(0);

        // Reset mid-ROUND.
        send(0, TWO1_B, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_outs("rst_round");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(0, ABC_B, 1'b1, 1'b1);
        wait_dig(0, lat);
        chk("rst_round_abc", dd[0], ABC_D);

        // Reset mid-OUT with digest pending; H returns to IV so a non-first block works.
        reset_n = 1'b0;
        #1;
        chk_reset_outs("rst_out");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(0, ABC_B, 1'b0, 1'b1);
        wait_dig(0, lat);
        chk("rst_out_abc", dd[0], ABC_D);
        take(0);

        // Random multi-block messages on every variant against the reference model.
        for (int i = 0; i < 4; i++) begin
            for (int m = 0; m < 2; m++) begin
                nblk = int'($urandom_range(1, 3));
                hm = IV_H;
                for (int b = 0; b < nblk; b++) begin
                    for (int j = 0; j < 16; j++) blk[511 - 32*j -: 32] = $urandom();
                    hm = ref_compress(hm, blk);
                    send(i, blk, (b == 0), (b == nblk - 1));
                    if (b != nblk - 1) begin
                        wait_idle(i);
                        chk("rand_no_mid_digest", 160'(dv[i]), 160'(0));
                    end
                end
                wait_dig(i, lat);
                chk("rand_latency", 160'(lat), 160'(80 / rv(i) + 1));
                chk("rand_digest", dd[i], hm);
                take(i);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
